// File: rtl/tenyr_serial_pkg.sv
// tenyr_serial_pkg: register offsets and STATUS/CONTROL bit positions for tenyr_serial_fifo.
package tenyr_serial_pkg;
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2
    } reg_e;
    localparam int ST_RX_NE   = 0;
    localparam int ST_TX_NF   = 1;
    localparam int ST_TX_OVF  = 2;
    localparam int ST_RX_UNF  = 3;
    localparam int ST_RX_CNT  = 8;
    localparam int ST_TX_CNT  = 16;
    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;
endpackage

// File: rtl/tenyr_serial_fifo_if.sv
// tenyr_serial_fifo_if: operand-bus and byte-stream signals of the serial device.
interface tenyr_serial_fifo_if #(parameter int DATA_W = 8);
    logic              enable;
    logic              rw;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              irq;
    modport master (
        output enable, rw, addr, wdata, tx_ready, rx_data, rx_valid,
        input  rdata, rdata_valid, tx_data, tx_valid, rx_ready, irq
    );
    modport slave (
        input  enable, rw, addr, wdata, tx_ready, rx_data, rx_valid,
        output rdata, rdata_valid, tx_data, tx_valid, rx_ready, irq
    );
endinterface

// File: rtl/tenyr_sync_fifo.sv
// tenyr_sync_fifo: single-clock FIFO with simultaneous push/pop, state updated on the falling edge.
module tenyr_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-2:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o = cnt_q == CNT_W'(DEPTH);
    assign do_pop = pop_i && !empty_o;
    // a pop frees the slot for a same-cycle push; an empty FIFO never forwards
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o = mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(negedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_q + (CNT_W-1)'(do_push);
            rd_q <= rd_q + (CNT_W-1)'(do_pop);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
    always_ff @(negedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/tenyr_serial_fifo.sv
// tenyr_serial_fifo: memory-mapped FIFO-buffered serial device on the tenyr operand bus.
// Define TENYR_SERIAL_IRQ_EN to build the CONTROL register and the interrupt output.
module tenyr_serial_fifo
    import tenyr_serial_pkg::*;
#(
    parameter logic [31:0] BASE = 32'd32,
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input logic clk,
    input logic reset,
    tenyr_serial_fifo_if.slave bus
);
    logic [31:0] off, status, ctrl_rd, rd_val, rdata_q;
    reg_e sel;
    logic hit, rd, wr, wr_status, rdata_valid_q;
    logic tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
    logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;
    logic [DATA_W-1:0] rx_head;
    // unsigned offset makes addresses below BASE decode as out of range
    assign off = bus.addr - BASE;
    assign sel = reg_e'(off[1:0]);
    assign hit = bus.enable && off < 32'd3;
    assign rd = hit && !bus.rw;
    assign wr = hit && bus.rw;
    assign wr_status = wr && sel == REG_STATUS;
    assign tx_push = wr && sel == REG_DATA;
    assign tx_pop = !tx_empty && bus.tx_ready;
    assign rx_push = bus.rx_valid && !rx_full;
    assign rx_pop = rd && sel == REG_DATA;
    tenyr_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
        .clk(clk), .rst(reset), .push_i(tx_push), .pop_i(tx_pop),
        .data_i(bus.wdata[DATA_W-1:0]), .data_o(bus.tx_data),
        .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
    );
    tenyr_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
        .clk(clk), .rst(reset), .push_i(rx_push), .pop_i(rx_pop),
        .data_i(bus.rx_data), .data_o(rx_head),
        .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
    );
    assign tx_ovf_d = (tx_push && tx_full && !tx_pop) || (tx_ovf_q && !(wr_status && bus.wdata[ST_TX_OVF]));
    assign rx_unf_d = (rx_pop && rx_empty) || (rx_unf_q && !(wr_status && bus.wdata[ST_RX_UNF]));
    always_comb begin
        status = '0;
        status[ST_RX_NE] = !rx_empty;
        status[ST_TX_NF] = !tx_full;
        status[ST_TX_OVF] = tx_ovf_q;
        status[ST_RX_UNF] = rx_unf_q;
        status[ST_RX_CNT +: 8] = 8'(rx_cnt);
        status[ST_TX_CNT +: 8] = 8'(tx_cnt);
    end
    assign rd_val = sel == REG_DATA ? (rx_empty ? '0 : 32'(rx_head)) :
                    sel == REG_STATUS ? status : ctrl_rd;
    always_ff @(negedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            rdata_valid_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            rdata_q <= rd ? rd_val : '0;
            rdata_valid_q <= rd;
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end
    assign bus.rdata = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.tx_valid = !tx_empty;
    assign bus.rx_ready = !rx_full;
`ifdef TENYR_SERIAL_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic irq_q;
    logic [CNT_W-1:0] rx_cnt_d, tx_cnt_d;
    assign ctrl_d = (wr && sel == REG_CTRL) ? bus.wdata[1:0] : ctrl_q;
    // irq tracks the post-edge FIFO state so it follows a push/pop with no extra cycle
    assign rx_cnt_d = rx_cnt + CNT_W'(rx_push) - CNT_W'(rx_pop && !rx_empty);
    assign tx_cnt_d = tx_cnt + CNT_W'(tx_push && (!tx_full || tx_pop)) - CNT_W'(tx_pop);
    always_ff @(negedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q <= (ctrl_d[CTRL_RX_IE] && rx_cnt_d != '0) || (ctrl_d[CTRL_TX_IE] && tx_cnt_d == '0);
        end
    end
    assign ctrl_rd = 32'(ctrl_q);
    assign bus.irq = irq_q;
`else
    assign ctrl_rd = '0;
    assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_tenyr_serial_fifo.sv
// tb_tenyr_serial_fifo: directed self-checking bench for tenyr_serial_fifo (BASE=32, DATA_W=8, DEPTH=16).
module tb_tenyr_serial_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;
`ifdef TENYR_SERIAL_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    tenyr_serial_fifo_if #(.DATA_W(8)) bus ();
    tenyr_serial_fifo #(.BASE(32'd32), .DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;

    // DUT state moves on the falling edge; sample and drive 1 time unit after it
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.enable = 1'b1;
        bus.rw = 1'b1;
        bus.addr = a;
        bus.wdata = d;
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.enable = 1'b1;
        bus.rw = 1'b0;
        bus.addr = a;
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input string tag, input logic [31:0] exp);
        rd(a);
        chk({tag, "_valid"}, 32'(bus.rdata_valid), 32'd1);
        chk(tag, bus.rdata, exp);
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.rw = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.tx_ready = 1'b0;
        bus.rx_data = '0;
        bus.rx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("rst_irq", 32'(bus.irq), 32'd0);

        rd_chk(33, "status_idle", 32'h0000_0002);
        tick();
        chk("rdata_valid_drop", 32'(bus.rdata_valid), 32'd0);
        chk("rdata_zero_idle", bus.rdata, 32'd0);

        wr(32, 32'h41);
        chk("tx_valid_after_push", 32'(bus.tx_valid), 32'd1);
        wr(32, 32'h142);
        chk("tx_head_41", 32'(bus.tx_data), 32'h41);
        rd_chk(33, "status_tx2", 32'h0002_0002);
        bus.tx_ready = 1'b1;
        tick();
        chk("tx_head_42", 32'(bus.tx_data), 32'h42);
        chk("tx_valid_one_left", 32'(bus.tx_valid), 32'd1);
        tick();
        chk("tx_drained", 32'(bus.tx_valid), 32'd0);
        bus.tx_ready = 1'b0;

        for (int i = 0; i < 17; i++) wr(32, 32'h60 + i);
        rd_chk(33, "status_tx_ovf", 32'h0010_0004);
        chk("tx_head_after_ovf", 32'(bus.tx_data), 32'h60);
        wr(33, 32'h0000_0004);
        rd_chk(33, "status_ovf_cleared", 32'h0010_0000);
        bus.tx_ready = 1'b1;
        wr(32, 32'h77);
        bus.tx_ready = 1'b0;
        chk("tx_full_pushpop_head", 32'(bus.tx_data), 32'h61);
        rd_chk(33, "status_full_pushpop", 32'h0010_0000);
        wr(35, 32'h33);
        wr(31, 32'h33);
        rd_chk(33, "status_out_of_range_wr", 32'h0010_0000);
        rd(31);
        chk("oob_read_no_valid", 32'(bus.rdata_valid), 32'd0);
        chk("oob_read_rdata", bus.rdata, 32'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_chk(33, "status_after_reset", 32'h0000_0002);

        bus.rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.rx_data = 8'(8'h10 + i);
            tick();
        end
        bus.rx_valid = 1'b0;
        chk("rx_ready_full", 32'(bus.rx_ready), 32'd0);
        rd_chk(33, "status_rx_full", 32'h0000_1003);
        rd_chk(32, "rx_first_char", 32'h10);
        chk("rx_ready_after_pop", 32'(bus.rx_ready), 32'd1);
        rd_chk(33, "status_rx15", 32'h0000_0F03);
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'hAA;
        tick();
        bus.rx_valid = 1'b0;
        chk("rx_ready_refull", 32'(bus.rx_ready), 32'd0);
        for (int i = 0; i < 16; i++)
            rd_chk(32, $sformatf("rx_drain_%0d", i), i < 15 ? 32'h11 + i : 32'hAA);
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h55;
        rd_chk(32, "rx_empty_read", 32'd0);
        bus.rx_valid = 1'b0;
        rd_chk(33, "status_rx_unf", 32'h0000_010B);
        wr(33, 32'h0000_0008);
        rd_chk(33, "status_unf_cleared", 32'h0000_0103);
        rd_chk(32, "rx_kept_push", 32'h55);

        for (int i = 0; i < 5; i++) wr(32, 32'h30 + i);
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rx_data = 8'(8'h20 + i);
            tick();
        end
        bus.rx_valid = 1'b0;
        rd_chk(33, "status_5_5", 32'h0005_0503);
        bus.enable = 1'b1;
        bus.rw = 1'b0;
        bus.addr = 33;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.enable = 1'b0;
        chk("midrst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
        chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("midrst_rx_ready", 32'(bus.rx_ready), 32'd1);
        rd_chk(33, "midrst_status", 32'h0000_0002);

        wr(34, 32'h1);
        chk("irq_rx_ie_empty", 32'(bus.irq), 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h5A;
        tick();
        bus.rx_valid = 1'b0;
        chk("irq_rx_pushed", 32'(bus.irq), 32'(IRQ_ON));
        rd_chk(32, "irq_rx_char", 32'h5A);
        chk("irq_after_pop", 32'(bus.irq), 32'd0);
        rd_chk(34, "ctrl_read", 32'(IRQ_ON));
        wr(34, 32'h2);
        chk("irq_tx_empty", 32'(bus.irq), 32'(IRQ_ON));
        wr(32, 32'h66);
        chk("irq_tx_nonempty", 32'(bus.irq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
